// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store unit for a word-organised data cache, with
//            sub-word load extraction and read-modify-write sub-word stores.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic [31:0] dCacheAddr,
  output logic        dCacheReadEn,
  output logic        dCacheWriteEn,
  output logic [31:0] dCacheWriteData,
  input  logic [31:0] dCacheReadData
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  state_e      state_q;
  logic        rsp_valid_q;
  logic        rsp_misalign_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] rmw_addr_q;
  logic [31:0] rmw_data_q;

  logic        w_accept;
  logic        w_fault;
  logic        w_load;
  logic        w_word_store;
  logic        w_sub_store;
  logic [31:0] w_word_idx;
  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;
  logic [31:0] w_lane_mask;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  logic [31:0] w_merged;

  assign req_ready  = !rst && (state_q == IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_word_idx = {2'b00, req_addr[31:2]};

  always_comb begin
    w_fault = 1'b0;
    case (req_size)
      c_SIZE_BYTE: w_fault = 1'b0;
      c_SIZE_HALF: w_fault = req_addr[0];
      c_SIZE_WORD: w_fault = |req_addr[1:0];
      default:     w_fault = 1'b1;
    endcase
  end

  assign w_load       = w_accept && !w_fault && !req_we;
  assign w_word_store = w_accept && !w_fault && req_we && (req_size == c_SIZE_WORD);
  assign w_sub_store  = w_accept && !w_fault && req_we && (req_size != c_SIZE_WORD);

  // Bit offset of the addressed lane; big-endian puts byte 0 in the top lane.
  always_comb begin
    w_shift = 5'd0;
    if (req_size == c_SIZE_BYTE) begin
      w_shift = BIG_ENDIAN ? {~req_addr[1:0], 3'b000} : {req_addr[1:0], 3'b000};
    end else if (req_size == c_SIZE_HALF) begin
      w_shift = BIG_ENDIAN ? {~req_addr[1], 4'b0000} : {req_addr[1], 4'b0000};
    end
  end

  assign w_lane = dCacheReadData >> w_shift;

  always_comb begin
    w_load_data = dCacheReadData;
    case (req_size)
      c_SIZE_BYTE: w_load_data = {{24{req_sext & w_lane[7]}}, w_lane[7:0]};
      c_SIZE_HALF: w_load_data = {{16{req_sext & w_lane[15]}}, w_lane[15:0]};
      default:     w_load_data = dCacheReadData;
    endcase
  end

  assign w_lane_mask = (req_size == c_SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign w_mask      = w_lane_mask << w_shift;
  assign w_ins       = (req_wdata & w_lane_mask) << w_shift;
  assign w_merged    = (dCacheReadData & ~w_mask) | w_ins;

  // The RMW write is dropped if reset lands in that cycle.
  assign dCacheAddr      = (state_q == RMW) ? rmw_addr_q : w_word_idx;
  assign dCacheReadEn    = w_load || w_sub_store;
  assign dCacheWriteEn   = ((state_q == RMW) && !rst) || w_word_store;
  assign dCacheWriteData = (state_q == RMW) ? rmw_data_q : req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
    end else begin
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            if (w_fault) begin
              rsp_valid_q    <= 1'b1;
              rsp_misalign_q <= 1'b1;
            end else if (w_sub_store) begin
              state_q    <= RMW;
              rmw_addr_q <= w_word_idx;
              rmw_data_q <= w_merged;
            end else begin
              rsp_valid_q <= 1'b1;
              if (!req_we) begin
                rsp_rdata_q <= w_load_data;
              end
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_misalign = rsp_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Randomized and directed bench for load_store_unit, both
//            endiannesses, against a byte-addressed behavioural model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  // Index 0: big-endian instance, index 1: little-endian instance.
  logic        rdy  [2];
  logic        rv   [2];
  logic        ms   [2];
  logic        re_o [2];
  logic        we_o [2];
  logic [31:0] rd   [2];
  logic [31:0] ca   [2];
  logic [31:0] wd   [2];
  logic [31:0] crd  [2];
  logic [31:0] mem  [2][16];

  load_store_unit #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]),
    .rsp_rdata(rd[0]), .rsp_misalign(ms[0]), .dCacheAddr(ca[0]),
    .dCacheReadEn(re_o[0]), .dCacheWriteEn(we_o[0]),
    .dCacheWriteData(wd[0]), .dCacheReadData(crd[0])
  );

  load_store_unit #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]),
    .rsp_rdata(rd[1]), .rsp_misalign(ms[1]), .dCacheAddr(ca[1]),
    .dCacheReadEn(re_o[1]), .dCacheWriteEn(we_o[1]),
    .dCacheWriteData(wd[1]), .dCacheReadData(crd[1])
  );

  // Word-organised cache: combinational read, write on posedge.
  assign crd[0] = mem[0][ca[0][3:0]];
  assign crd[1] = mem[1][ca[1][3:0]];
  always @(posedge clk) begin
    if (we_o[0]) mem[0][ca[0][3:0]] <= wd[0];
    if (we_o[1]) mem[1][ca[1][3:0]] <= wd[1];
  end

  // Reference model: plain byte-addressed memory per instance.
  logic [7:0] rb [2][64];

  typedef struct {
    int          due;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        mis;
  } rsp_t;
  rsp_t q[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          done = 1'b0;
  logic        x_ready = 1'b0;
  logic        x_re = 1'b0;
  logic        x_we = 1'b0;
  logic [31:0] x_addr = '0;
  logic [31:0] x_wd [2];

  bit          pend = 1'b0;
  int          pend_cyc, pend_a, pend_sz;
  logic [31:0] pend_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit mfault(input int a, input int sz);
    return (sz == 3) || ((a % (1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] mload(input int e, input int a, input int sz, input bit sx);
    int n = 1 << sz;
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) begin
      if (e == 0) v = (v << 8) | {24'b0, rb[e][a+k]};
      else        v = v | ({24'b0, rb[e][a+k]} << (8 * k));
    end
    if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic mstore(input int e, input int a, input int sz, input logic [31:0] w);
    int n = 1 << sz;
    for (int k = 0; k < n; k++)
      rb[e][a+k] = (e == 0) ? w[8*(n-1-k) +: 8] : w[8*k +: 8];
  endtask

  function automatic logic [31:0] mword(input int e, input int i);
    return mload(e, 4 * i, 2, 1'b0);
  endfunction

  function automatic rsp_t mk(input int due, input logic [31:0] d0, input logic [31:0] d1, input logic mis);
    rsp_t r;
    r.due = due; r.d0 = d0; r.d1 = d1; r.mis = mis;
    return r;
  endfunction

  // One clock cycle: update model, record expectations, drive the DUTs.
  task automatic step(input bit r, input bit v, input bit w, input int sz,
                      input bit sx, input int a, input logic [31:0] wdat);
    bit rmw_now;
    @(posedge clk);
    #2;
    cyc++;
    rmw_now = pend && (pend_cyc == cyc);
    x_ready = !r && !rmw_now;
    x_re = 1'b0;
    x_we = 1'b0;
    x_addr = '0;
    if (rmw_now) begin
      pend = 1'b0;
      if (!r) begin
        for (int e = 0; e < 2; e++) begin
          mstore(e, pend_a, pend_sz, pend_w);
          x_wd[e] = mword(e, pend_a / 4);
        end
        x_we = 1'b1;
        x_addr = pend_a / 4;
        q.push_back(mk(cyc + 1, 32'h0, 32'h0, 1'b0));
      end
    end
    if (v && x_ready) begin
      if (mfault(a, sz)) begin
        q.push_back(mk(cyc + 1, 32'h0, 32'h0, 1'b1));
      end else if (!w) begin
        x_re = 1'b1;
        x_addr = a / 4;
        q.push_back(mk(cyc + 1, mload(0, a, sz, sx), mload(1, a, sz, sx), 1'b0));
      end else if (sz == 2) begin
        for (int e = 0; e < 2; e++) begin
          mstore(e, a, sz, wdat);
          x_wd[e] = mword(e, a / 4);
        end
        x_we = 1'b1;
        x_addr = a / 4;
        q.push_back(mk(cyc + 1, 32'h0, 32'h0, 1'b0));
      end else begin
        x_re = 1'b1;
        x_addr = a / 4;
        pend = 1'b1;
        pend_cyc = cyc + 1;
        pend_a = a;
        pend_sz = sz;
        pend_w = wdat;
      end
    end
    rst = r;
    req_valid = v;
    req_we = w;
    req_size = sz[1:0];
    req_sext = sx;
    req_addr = a;
    req_wdata = wdat;
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && !done) begin
      rsp_t h;
      bit   hv;
      hv = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        h = q.pop_front();
        hv = 1'b1;
      end
      for (int e = 0; e < 2; e++) begin
        chk(e == 0 ? "be_ready" : "le_ready", {31'b0, rdy[e]}, {31'b0, x_ready});
        chk(e == 0 ? "be_rd_en" : "le_rd_en", {31'b0, re_o[e]}, {31'b0, x_re});
        chk(e == 0 ? "be_wr_en" : "le_wr_en", {31'b0, we_o[e]}, {31'b0, x_we});
        if (x_re || x_we) chk(e == 0 ? "be_cache_addr" : "le_cache_addr", ca[e], x_addr);
        if (x_we) chk(e == 0 ? "be_wr_data" : "le_wr_data", wd[e], x_wd[e]);
        chk(e == 0 ? "be_rsp_valid" : "le_rsp_valid", {31'b0, rv[e]}, {31'b0, hv});
        if (hv) begin
          chk(e == 0 ? "be_rsp_rdata" : "le_rsp_rdata", rd[e], (e == 0) ? h.d0 : h.d1);
          chk(e == 0 ? "be_rsp_misalign" : "le_rsp_misalign", {31'b0, ms[e]}, {31'b0, h.mis});
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (i == 1) ? 32'h80F0_1234 : $urandom;
      mem[0][i] <= w;
      mem[1][i] <= w;
      mstore(0, 4 * i, 2, w);
      mstore(1, 4 * i, 2, w);
    end

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", {31'b0, rv[0]}, 32'h0);
    chk("reset_rsp_rdata", rd[0], 32'h0);
    chk("reset_rsp_misalign", {31'b0, ms[0]}, 32'h0);

    chk("pin_lb", mload(0, 4, 0, 1), 32'hFFFF_FF80);
    chk("pin_lbu", mload(0, 5, 0, 0), 32'h0000_00F0);
    chk("pin_lh", mload(0, 6, 1, 1), 32'h0000_1234);
    chk("pin_lw", mload(0, 4, 2, 0), 32'h80F0_1234);
    chk("pin_le_lbu", mload(1, 4, 0, 0), 32'h0000_0034);
    step(0, 1, 0, 0, 1, 4, 0);
    step(0, 1, 0, 0, 0, 5, 0);
    step(0, 1, 0, 1, 1, 6, 0);
    step(0, 1, 0, 2, 0, 4, 0);
    step(0, 1, 0, 0, 0, 4, 0);

    chk("pin_fault_lw6", {31'b0, mfault(6, 2)}, 32'h1);
    chk("pin_fault_sh5", {31'b0, mfault(5, 1)}, 32'h1);
    chk("pin_fault_sz3", {31'b0, mfault(8, 3)}, 32'h1);
    step(0, 1, 0, 2, 0, 6, 0);
    step(0, 1, 1, 1, 0, 5, 32'h0000_7777);
    step(0, 1, 0, 3, 0, 8, 0);

    step(0, 1, 1, 1, 0, 4, 32'h0000_5555);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("pin_rst_rmw_word", mword(0, 1), 32'h80F0_1234);

    step(0, 1, 1, 0, 0, 7, 32'h0000_00AB);
    step(0, 1, 0, 2, 0, 4, 0);
    chk("pin_sb_merge", mword(0, 1), 32'h80F0_12AB);
    step(0, 1, 0, 2, 0, 4, 0);

    step(0, 1, 1, 2, 0, 8, 32'hDEAD_BEEF);
    chk("pin_lhu_after_sw", mload(0, 10, 1, 0), 32'h0000_BEEF);
    step(0, 1, 0, 2, 0, 8, 0);
    step(0, 1, 0, 1, 0, 10, 0);

    for (int n = 0; n < 600; n++) begin
      int sz, a;
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 63));
      if (sz < 3 && $urandom_range(0, 9) < 8) a = a & ~((1 << sz) - 1);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
           sz, $urandom_range(0, 1) == 1, a, $urandom);
    end

    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    done = 1'b1;
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 16; i++)
        chk(e == 0 ? "be_final_mem" : "le_final_mem", mem[e][i], mword(e, i));
    chk("rsp_queue_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the pipeline's MEM stage and the word-organised data cache. It converts byte addresses to word indices and performs sub-word extraction with sign or zero extension on loads. Byte and halfword stores are done as a two-cycle read-modify-write, because the cache only writes whole 32-bit words. Misaligned accesses are flagged back to the pipeline and never reach the cache.

## Interface
- `BIG_ENDIAN`, default 1: 1 means byte 0 of a word is bits [31:24] (MIPS big-endian); 0 means byte 0 is bits [7:0].
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_sext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle completion pulse per accepted request.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_misalign` out 1: request faulted, valid with `rsp_valid`.
- `dCacheAddr` out 32: word index = {2'b00, addr[31:2]}.
- `dCacheReadEn` out 1: cache read strobe (cache read is combinational).
- `dCacheWriteEn` out 1: cache write strobe (cache writes on posedge).
- `dCacheWriteData` out 32: full word to write.
- `dCacheReadData` in 32: cache read word.

## Operation
- States: IDLE, RMW.
- **Fault check** (IDLE, on accept):
  - `req_size`=11 faults.
  - Halfword faults if addr[0]=1.
  - Word faults if addr[1:0]≠00.
  - A fault gives no cache strobe; next cycle `rsp_valid`=1, `rsp_misalign`=1, `rsp_rdata`=0.
- **Load** (IDLE, no fault):
  - `dCacheReadEn`=1 on accept.
  - Lane selected by addr[1:0] (byte) or addr[1] (half), per `BIG_ENDIAN`.
  - Extended per `req_sext` (word ignores it).
  - Registered into `rsp_rdata`.
- **Word store** (IDLE):
  - `dCacheWriteEn`=1 and `dCacheWriteData`=`req_wdata` on accept.
  - Stay IDLE.
- **Byte/half store**:
  - Accept cycle: `dCacheReadEn`=1. Register the word index and the merged word (read word with the addressed lane replaced by `req_wdata`[7:0] or [15:0]). Go to RMW.
  - RMW cycle: `dCacheAddr`=latched index, `dCacheWriteEn`=1, `dCacheWriteData`=merged word, `req_ready`=0, `dCacheReadEn`=0. Return to IDLE.
- `req_ready`=1 in IDLE (except during reset), 0 in RMW.
- No strobe is asserted unless a request is accepted or the unit is in RMW.
- `dCacheAddr` carries don't-care values while idle.
- `dCacheReadEn` and `dCacheWriteEn` are never both 1 in the same cycle.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_misalign`=0.
- While `rst`=1: `req_ready`=0, `dCacheReadEn`=0, `dCacheWriteEn`=0.
- Latency from accept cycle N:
  - Loads, word stores, faults: `rsp_valid` in N+1.
  - Sub-word stores: write in N+1, `rsp_valid` in N+2.
- Throughput: one load or word store per cycle back-to-back. A sub-word store blocks the next accept for exactly one cycle.
- A request arriving during RMW is held by the upstream stage (`req_ready`=0). It is accepted in the first IDLE cycle.
- Load after store to the same word:
  - Word store: cache updated at edge ending N, so a load in N+1 sees the new data.
  - Sub-word store: load accepted in N+2 sees the merged word.
- Reset asserted in RMW cycle: write suppressed, memory unchanged, no response. IDLE the cycle after `rst` deasserts.
- `rsp_*` are registered outputs. `rsp_valid` is high for exactly one cycle per accepted request.

## Test plan
All cases use `BIG_ENDIAN`=1 with word index 1 (byte address 4) preloaded to 0x80F01234, unless stated otherwise.
- **Loads:**
  - LB (sext) @4 → next cycle `rsp_rdata`=0xFFFFFF80.
  - LBU @5 → 0x000000F0.
  - LH (sext) @6 → 0x00001234.
  - LW @4 → 0x80F01234.
- **Sub-word store:** SB `req_wdata`=0x000000AB @7 → cycle N `dCacheReadEn`=1. Cycle N+1: `req_ready`=0, `dCacheWriteEn`=1, `dCacheAddr`=1, data 0x80F012AB. `rsp_valid` in N+2. LW @4 then returns 0x80F012AB.
- **Misalignment:** LW @6, then SH @5, then `req_size`=11 @8 → each gives `rsp_misalign`=1, `rsp_rdata`=0, zero cache strobes. Memory unchanged.
- **Back-to-back:** SW 0xDEADBEEF @8, then LW @8, then LHU @10 in consecutive cycles → responses 0 / 0xDEADBEEF / 0x0000BEEF in consecutive cycles.
- **Reset mid-RMW:** SH 0x5555 @4, `rst`=1 in the RMW cycle → `dCacheWriteEn`=0, no `rsp_valid`. Word stays 0x80F01234; `req_ready`=1 one cycle after `rst` falls.
- **Little-endian:** `BIG_ENDIAN`=0, LBU @4 → 0x00000034.
